// File: rtl/timer_pkg.sv
// Shared constants and types for the timer APB port.
// Register offsets, STATUS bit positions, APB FSM states, compare reset value.
package timer_pkg;

    localparam logic [11:0] OFF_CNT_LO = 12'h004;
    localparam logic [11:0] OFF_CNT_HI = 12'h008;
    localparam logic [11:0] OFF_CMP_LO = 12'h00C;
    localparam logic [11:0] OFF_CMP_HI = 12'h010;
    localparam logic [11:0] OFF_STATUS = 12'h014;

    localparam int ST_PEND = 0;
    localparam int ST_EN   = 1;
    localparam int ST_SNAP = 2;

    localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

endpackage

// File: rtl/timer_cmp.sv
// 64-bit compare registers, unsigned >= comparator and level interrupt.
// Ports: clk, rst_n, cnt, wr_lo/wr_hi/wr_status strobes + wdata; cmp_lo/hi, irq_pending, irq_en, tmr_irq.
import timer_pkg::*;

module timer_cmp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] cnt,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic        wr_status,
    input  logic [31:0] wdata,
    output logic [31:0] cmp_lo,
    output logic [31:0] cmp_hi,
    output logic        irq_pending,
    output logic        irq_en,
    output logic        tmr_irq
);

    logic hit;

    assign hit     = (cnt >= {cmp_hi, cmp_lo});
    assign tmr_irq = irq_pending & irq_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_lo      <= CMP_RST[31:0];
            cmp_hi      <= CMP_RST[63:32];
            irq_pending <= 1'b0;
            irq_en      <= 1'b0;
        end else begin
            if (wr_lo)
                cmp_lo <= wdata;
            if (wr_hi)
                cmp_hi <= wdata;
            if (wr_status)
                irq_en <= wdata[ST_EN];
            // a live compare hit beats a same-edge W1C
            if (hit)
                irq_pending <= 1'b1;
            else if (wr_status && wdata[ST_PEND])
                irq_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/timer_apb_port.sv
// APB3 responder: coherent 64-bit count reads, compare and STATUS registers.
// Ports: clk, rst_n, APB (psel..pslverr), cnt from counter block, tmr_irq.
import timer_pkg::*;

module timer_apb_port #(
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic [63:0] cnt,
    output logic        tmr_irq
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    apb_state_t  state, state_d, phase;
    logic [3:0]  wait_cnt;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] snap_hi;
    logic        snap_valid;
    logic [11:0] off;
    logic        wr_ok;
    logic [31:0] cmp_lo, cmp_hi;
    logic        irq_pending, irq_en;
    logic        unused_ok;

    // window hit is decoded upstream; only the 4 KB offset matters here
    assign unused_ok = ^{paddr[31:12], BASE_ADDR};
    assign off       = paddr[11:0];

    // the setup cycle is the idle cycle that sees psel & !penable
    assign phase = (state == IDLE && psel && !penable) ? SETUP : state;

    assign pready  = (state == ACCESS) && (wait_cnt == WS);
    assign prdata  = (state == ACCESS) ? rdata_q : 32'd0;
    assign pslverr = (state == ACCESS) ? err_q : 1'b0;

    always_comb begin
        state_d = state;
        unique case (phase)
            IDLE:    state_d = IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready || !psel) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
        unique case (off)
            OFF_CNT_LO: rdata_d = cnt[31:0];
            OFF_CNT_HI: rdata_d = snap_valid ? snap_hi : cnt[63:32];
            OFF_CMP_LO: rdata_d = cmp_lo;
            OFF_CMP_HI: rdata_d = cmp_hi;
            OFF_STATUS: rdata_d = {29'd0, snap_valid, irq_en, irq_pending};
            default:    err_d = 1'b1;
        endcase
        if (pwrite)
            rdata_d = 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
            snap_hi    <= 32'd0;
            snap_valid <= 1'b0;
        end else begin
            state <= state_d;
            if (phase == SETUP) begin
                wait_cnt <= 4'd0;
                rdata_q  <= rdata_d;
                err_q    <= err_d;
                if (!pwrite && off == OFF_CNT_LO) begin
                    snap_hi    <= cnt[63:32];
                    snap_valid <= 1'b1;
                end
                if (!pwrite && off == OFF_CNT_HI)
                    snap_valid <= 1'b0;
            end else if (state == ACCESS && wait_cnt != WS) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    assign wr_ok = (state == ACCESS) && psel && penable && pready
                   && pwrite && !err_q;

    timer_cmp u_cmp (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt         (cnt),
        .wr_lo       (wr_ok && off == OFF_CMP_LO),
        .wr_hi       (wr_ok && off == OFF_CMP_HI),
        .wr_status   (wr_ok && off == OFF_STATUS),
        .wdata       (pwdata),
        .cmp_lo      (cmp_lo),
        .cmp_hi      (cmp_hi),
        .irq_pending (irq_pending),
        .irq_en      (irq_en),
        .tmr_irq     (tmr_irq)
    );

endmodule

// File: tb/tb_timer_apb_port.sv
// Directed bench for timer_apb_port: zero-wait and two-wait instances.
// Each task drives one scenario and checks inline against hand values.
module tb_timer_apb_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        psel0 = 1'b0, psel1 = 1'b0;
    logic        penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = 32'd0, pwdata = 32'd0;
    logic [63:0] cnt = 64'd0;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;
    logic        tmr_irq0, tmr_irq1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_apb_port #(.BASE_ADDR(32'h2000_0000), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
        .cnt(cnt), .tmr_irq(tmr_irq0)
    );

    timer_apb_port #(.BASE_ADDR(32'h2000_0000), .WAIT_STATES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .psel(psel1), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1),
        .cnt(cnt), .tmr_irq(tmr_irq1)
    );

    task automatic apb(input int d, input logic wr, input logic [11:0] off,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic er, output int waits, output logic to);
        @(posedge clk); #1;
        if (d == 0) psel0 = 1'b1; else psel1 = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = 32'h2000_0000 | {20'd0, off};
        pwdata  = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        to    = 1'b1;
        rd    = 32'd0;
        er    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((d == 0) ? pready0 : pready1) begin
                rd = (d == 0) ? prdata0 : prdata1;
                er = (d == 0) ? pslverr0 : pslverr1;
                to = 1'b0;
                break;
            end
            waits++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        psel0 = 1'b0;
        psel1 = 1'b0;
        penable = 1'b0;
        pwrite = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er, to; int w;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (prdata0 !== 32'd0) begin
            errors++; $display("FAIL rst_prdata got %h exp 0", prdata0);
        end
        checks++;
        if (pready0 !== 1'b0 || pslverr0 !== 1'b0) begin
            errors++; $display("FAIL rst_ready_err got %b%b exp 00", pready0, pslverr0);
        end
        checks++;
        if (tmr_irq0 !== 1'b0) begin
            errors++; $display("FAIL rst_irq got %b exp 0", tmr_irq0);
        end
        rst_n = 1'b1;
        apb(0, 1'b0, 12'h014, 32'd0, rd, er, w, to);
        checks++;
        if (to || rd !== 32'd0 || er !== 1'b0) begin
            errors++; $display("FAIL rst_status got %h err %b to %b exp 0", rd, er, to);
        end
        apb(0, 1'b0, 12'h00C, 32'd0, rd, er, w, to);
        checks++;
        if (to || rd !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL rst_cmp_lo got %h exp ffffffff", rd);
        end
        @(negedge clk);
        checks++;
        if (prdata0 !== 32'd0) begin
            errors++; $display("FAIL idle_prdata got %h exp 0", prdata0);
        end
    endtask

    task automatic test_snapshot();
        logic [31:0] rd; logic er, to; int w;
        cnt = 64'h0000_0001_FFFF_FFFE;
        apb(0, 1'b0, 12'h004, 32'd0, rd, er, w, to);
        checks++;
        if (to || rd !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL cnt_lo got %h exp fffffffe", rd);
        end
        cnt = 64'h0000_0002_0000_0001;
        apb(0, 1'b0, 12'h014, 32'd0, rd, er, w, to);
        checks++;
        if (to || rd !== 32'h4) begin
            errors++; $display("FAIL snap_status got %h exp 4", rd);
        end
        apb(0, 1'b0, 12'h008, 32'd0, rd, er, w, to);
        checks++;
        if (to || rd !== 32'h1) begin
            errors++; $display("FAIL cnt_hi_snap got %h exp 1", rd);
        end
        apb(0, 1'b0, 12'h014, 32'd0, rd, er, w, to);
        checks++;
        if (to || rd !== 32'h0) begin
            errors++; $display("FAIL snap_clear got %h exp 0", rd);
        end
        apb(0, 1'b0, 12'h008, 32'd0, rd, er, w, to);
        checks++;
        if (to || rd !== 32'h2) begin
            errors++; $display("FAIL cnt_hi_live got %h exp 2", rd);
        end
    endtask

    task automatic test_compare();
        logic [31:0] rd; logic er, to; int w;
        cnt = 64'd0;
        apb(0, 1'b1, 12'h010, 32'h0, rd, er, w, to);
        apb(0, 1'b1, 12'h00C, 32'h100, rd, er, w, to);
        apb(0, 1'b1, 12'h014, 32'h2, rd, er, w, to);
        checks++;
        if (to || er !== 1'b0) begin
            errors++; $display("FAIL wr_status_err got %b exp 0", er);
        end
        apb(0, 1'b0, 12'h00C, 32'd0, rd, er, w, to);
        checks++;
        if (to || rd !== 32'h100) begin
            errors++; $display("FAIL cmp_lo_rb got %h exp 100", rd);
        end
        cnt = 64'hFE;
        @(posedge clk); #1;
        cnt = 64'hFF;
        @(posedge clk); #1;
        checks++;
        if (tmr_irq0 !== 1'b0) begin
            errors++; $display("FAIL irq_early_ff got %b exp 0", tmr_irq0);
        end
        cnt = 64'h100;
        #1;
        checks++;
        if (tmr_irq0 !== 1'b0) begin
            errors++; $display("FAIL irq_before_edge got %b exp 0", tmr_irq0);
        end
        @(posedge clk); #1;
        checks++;
        if (tmr_irq0 !== 1'b1) begin
            errors++; $display("FAIL irq_rise got %b exp 1", tmr_irq0);
        end
        cnt = 64'h101;
        @(posedge clk); #1;
        apb(0, 1'b0, 12'h014, 32'd0, rd, er, w, to);
        checks++;
        if (to || rd !== 32'h3) begin
            errors++; $display("FAIL status_pend got %h exp 3", rd);
        end
    endtask

    task automatic test_w1c();
        logic [31:0] rd; logic er, to; int w;
        apb(0, 1'b1, 12'h014, 32'h3, rd, er, w, to);
        apb(0, 1'b0, 12'h014, 32'd0, rd, er, w, to);
        checks++;
        if (to || rd !== 32'h3) begin
            errors++; $display("FAIL w1c_set_wins got %h exp 3", rd);
        end
        apb(0, 1'b1, 12'h010, 32'h1, rd, er, w, to);
        apb(0, 1'b1, 12'h014, 32'h3, rd, er, w, to);
        #1;
        checks++;
        if (tmr_irq0 !== 1'b0) begin
            errors++; $display("FAIL w1c_irq got %b exp 0", tmr_irq0);
        end
        apb(0, 1'b0, 12'h014, 32'd0, rd, er, w, to);
        checks++;
        if (to || rd !== 32'h2) begin
            errors++; $display("FAIL w1c_status got %h exp 2", rd);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic er, to; int w;
        apb(1, 1'b0, 12'h00C, 32'd0, rd, er, w, to);
        checks++;
        if (to || w != 2 || rd !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL ws_read got %h waits %0d exp ffffffff waits 2", rd, w);
        end
        apb(1, 1'b0, 12'h020, 32'd0, rd, er, w, to);
        checks++;
        if (to || er !== 1'b1 || rd !== 32'd0) begin
            errors++; $display("FAIL bad_off got %h err %b exp 0 err 1", rd, er);
        end
        apb(0, 1'b1, 12'h018, 32'h5, rd, er, w, to);
        checks++;
        if (to || er !== 1'b1) begin
            errors++; $display("FAIL bad_off_wr err %b exp 1", er);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er, to; int w;
        @(posedge clk); #1;
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h2000_000C; pwdata = 32'h55;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        checks++;
        if (pready1 !== 1'b0) begin
            errors++; $display("FAIL abort_ready got %b exp 0", pready1);
        end
        @(posedge clk); #1;
        psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        repeat (2) @(posedge clk);
        apb(1, 1'b0, 12'h00C, 32'd0, rd, er, w, to);
        checks++;
        if (to || er !== 1'b0 || w != 2 || rd !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL abort_cmp got %h waits %0d exp ffffffff waits 2", rd, w);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h2000_000C; pwdata = 32'h200;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        checks++;
        if (pready0 !== 1'b1) begin
            errors++; $display("FAIL b2b_wr_ready got %b exp 1", pready0);
        end
        @(posedge clk); #1;
        penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        checks++;
        if (pready0 !== 1'b1 || prdata0 !== 32'h200) begin
            errors++; $display("FAIL b2b_rd got %h ready %b exp 200 ready 1", prdata0, pready0);
        end
        @(posedge clk); #1;
        psel0 = 1'b0; penable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_snapshot();
        test_compare();
        test_w1c();
        test_wait_states();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
